// File: rtl/icmp_rx.sv
// icmp_rx: watches an ICMP byte stream and pulses a reply request with the
// Sequence Number whenever a complete Echo Request (Type 8) frame arrives.
module icmp_rx (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_icmp_data,
  input  logic [15:0] i_icmp_len,
  input  logic        i_icmp_last,
  input  logic        i_icmp_valid,
  output logic [15:0] o_trig_seq,
  output logic        o_trig_reply
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned SEQ_W = 16;

  localparam logic [7:0]       TYPE_ECHO_REQ = 8'd8;
  localparam logic [IDX_W-1:0] IDX_TYPE      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_SEQ_HI    = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_SEQ_LO    = IDX_W'(7);
  localparam logic [IDX_W-1:0] IDX_MAX       = {IDX_W{1'b1}};

  logic [IDX_W-1:0] index_q,     index_d;
  logic [7:0]       type_q,      type_d;
  logic [SEQ_W-1:0] seq_q,       seq_d;
  logic [SEQ_W-1:0] trig_seq_q,  trig_seq_d;
  logic             trig_reply_q, trig_reply_d;

  // Frame length is informational only; nothing in the decode depends on it.
  logic unused_len;
  assign unused_len = ^i_icmp_len;

  // Next-state: byte indexing, header capture and frame qualification.
  always_comb begin
    index_d      = index_q;
    type_d       = type_q;
    seq_d        = seq_q;
    trig_seq_d   = trig_seq_q;
    trig_reply_d = 1'b0;

    if (i_icmp_valid) begin
      if (index_q == IDX_TYPE)   type_d       = i_icmp_data;
      if (index_q == IDX_SEQ_HI) seq_d[15:8]  = i_icmp_data;
      if (index_q == IDX_SEQ_LO) seq_d[7:0]   = i_icmp_data;

      if (i_icmp_last) begin
        index_d = '0;
        // seq_d already holds the LSB when the last beat lands on index 7.
        if ((index_q >= IDX_SEQ_LO) && (type_q == TYPE_ECHO_REQ)) begin
          trig_reply_d = 1'b1;
          trig_seq_d   = seq_d;
        end
      end else if (index_q != IDX_MAX) begin
        // Saturate so very long payloads never alias back onto header bytes.
        index_d = index_q + IDX_W'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      index_q      <= '0;
      type_q       <= '0;
      seq_q        <= '0;
      trig_seq_q   <= '0;
      trig_reply_q <= 1'b0;
    end else begin
      index_q      <= index_d;
      type_q       <= type_d;
      seq_q        <= seq_d;
      trig_seq_q   <= trig_seq_d;
      trig_reply_q <= trig_reply_d;
    end
  end

  assign o_trig_seq   = trig_seq_q;
  assign o_trig_reply = trig_reply_q;

endmodule

// File: tb/tb_icmp_rx.sv
// Directed bench for icmp_rx: hand-built frames with expected pulses/sequence.
module tb_icmp_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic [15:0] len;
  logic        last;
  logic        valid;
  logic [15:0] trig_seq;
  logic        trig_reply;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [7:0] fb [0:15];
  int         fn;

  icmp_rx dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_icmp_data  (data),
    .i_icmp_len   (len),
    .i_icmp_last  (last),
    .i_icmp_valid (valid),
    .o_trig_seq   (trig_seq),
    .o_trig_reply (trig_reply)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the reply pulse is high, sampled mid-cycle.
  always @(negedge clk) if (trig_reply === 1'b1) pulses++;

  task automatic beat(input logic [7:0] d, input logic l);
    valid = 1'b1; data = d; last = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid = 1'b0; last = 1'b0; data = 8'h00;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic mk_frame(input logic [7:0] typ, input logic [15:0] seq, input int n);
    fb[0] = typ;  fb[1] = 8'h00; fb[2] = 8'h12; fb[3] = 8'h34;
    fb[4] = 8'h01; fb[5] = 8'h01; fb[6] = seq[15:8]; fb[7] = seq[7:0];
    for (int i = 8; i < 16; i++) fb[i] = 8'h08;
    fn  = n;
    len = 16'(n);
  endtask

  // Sends fb[0..fn-1]; optional idle gaps after two chosen indices.
  task automatic send_frame(input int g1, input int g2, input int gap);
    for (int i = 0; i < fn; i++) begin
      beat(fb[i], (i == fn - 1) ? 1'b1 : 1'b0);
      if ((i == g1 || i == g2) && i != fn - 1 && gap > 0) idle(gap);
    end
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic er, input logic [15:0] es);
    checks++;
    if (trig_reply !== er || trig_seq !== es) begin
      errors++;
      $display("FAIL %s: reply=%b seq=%h, expected reply=%b seq=%h",
               name, trig_reply, trig_seq, er, es);
    end
  endtask

  task automatic expect_pulses(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: pulse count %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b1; data = 8'h08; last = 1'b1; len = 16'd0;
    @(negedge clk); @(negedge clk);
    expect_out("reset_state", 1'b0, 16'h0000);
    valid = 1'b0; last = 1'b0;
    rst = 1'b1;
    idle(2);
    expect_out("post_reset_idle", 1'b0, 16'h0000);
    expect_pulses("reset_no_pulse", pulses, 0);
  endtask

  task automatic test_echo();
    int p0;
    p0 = pulses;
    mk_frame(8'h08, 16'h0606, 12);
    fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03;
    send_frame(-1, -1, 0);
    expect_out("echo_pulse", 1'b1, 16'h0606);
    idle(1);
    expect_out("echo_pulse_drop", 1'b0, 16'h0606);
    // Same frame again after the single idle cycle.
    send_frame(-1, -1, 0);
    expect_out("repeat_pulse", 1'b1, 16'h0606);
    idle(2);
    expect_out("repeat_hold", 1'b0, 16'h0606);
    expect_pulses("repeat_two_pulses", pulses - p0, 2);
  endtask

  task automatic test_non_echo();
    int p0;
    p0 = pulses;
    mk_frame(8'h00, 16'h1234, 10);
    send_frame(-1, -1, 0);
    expect_out("non_echo_no_pulse", 1'b0, 16'h0606);
    idle(2);
    expect_pulses("non_echo_count", pulses - p0, 0);
  endtask

  task automatic test_gaps();
    int p0;
    p0 = pulses;
    mk_frame(8'h08, 16'hABCD, 10);
    send_frame(2, 5, 3);
    expect_out("gap_pulse", 1'b1, 16'hABCD);
    idle(2);
    expect_pulses("gap_count", pulses - p0, 1);
  endtask

  task automatic test_runt();
    int p0;
    p0 = pulses;
    mk_frame(8'h08, 16'h0000, 5);
    send_frame(-1, -1, 0);
    expect_out("runt5_no_pulse", 1'b0, 16'hABCD);
    idle(1);
    // Last beat at index 6: one byte short of a full header.
    mk_frame(8'h08, 16'h4242, 7);
    send_frame(-1, -1, 0);
    expect_out("runt7_no_pulse", 1'b0, 16'hABCD);
    idle(1);
    // Minimal header: last beat exactly at index 7.
    mk_frame(8'h08, 16'h0001, 8);
    send_frame(-1, -1, 0);
    expect_out("min_len_pulse", 1'b1, 16'h0001);
    idle(2);
    expect_pulses("runt_count", pulses - p0, 1);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses;
    mk_frame(8'h08, 16'h1111, 8);
    send_frame(-1, -1, 0);
    expect_out("b2b_first", 1'b1, 16'h1111);
    mk_frame(8'h08, 16'h2222, 9);
    send_frame(-1, -1, 0);
    expect_out("b2b_second", 1'b1, 16'h2222);
    // Non-echo straight after: its first byte must be taken as the Type.
    mk_frame(8'h00, 16'h3333, 8);
    send_frame(-1, -1, 0);
    expect_out("b2b_non_echo", 1'b0, 16'h2222);
    idle(2);
    expect_pulses("b2b_count", pulses - p0, 2);
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulses;
    mk_frame(8'h08, 16'h0606, 12);
    fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03;
    for (int i = 0; i < 4; i++) beat(fb[i], 1'b0);
    valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // Remainder now decodes as a fresh frame whose Type is 0x01.
    for (int i = 4; i < 12; i++) beat(fb[i], (i == 11) ? 1'b1 : 1'b0);
    valid = 1'b0; last = 1'b0;
    expect_out("reset_mid_no_pulse", 1'b0, 16'h0000);
    idle(1);
    mk_frame(8'h08, 16'h5555, 10);
    send_frame(-1, -1, 0);
    expect_out("reset_mid_next", 1'b1, 16'h5555);
    idle(2);
    expect_pulses("reset_mid_count", pulses - p0, 1);
  endtask

  task automatic test_reset_pulse();
    mk_frame(8'h08, 16'h6789, 8);
    send_frame(-1, -1, 0);
    expect_out("pulse_before_reset", 1'b1, 16'h6789);
    rst = 1'b0;
    @(negedge clk);
    expect_out("reset_in_pulse", 1'b0, 16'h0000);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_saturate();
    int p0;
    p0 = pulses;
    mk_frame(8'h08, 16'h7777, 8);
    len = 16'hFFFF;
    for (int i = 0; i < 8; i++) beat(fb[i], 1'b0);
    // Zero payload: a wrapping index would recapture Type 0 and suppress the pulse.
    for (int i = 8; i < 65545; i++) beat(8'h00, (i == 65544) ? 1'b1 : 1'b0);
    valid = 1'b0; last = 1'b0;
    expect_out("saturate_pulse", 1'b1, 16'h7777);
    idle(2);
    expect_pulses("saturate_count", pulses - p0, 1);
    mk_frame(8'h08, 16'h8888, 8);
    send_frame(-1, -1, 0);
    expect_out("after_long_frame", 1'b1, 16'h8888);
    idle(1);
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00; len = 16'h0000;
    @(negedge clk);
    test_reset();
    test_echo();
    test_non_echo();
    test_gaps();
    test_runt();
    test_back_to_back();
    test_reset_mid();
    test_reset_pulse();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
